// File: rtl/butterfly_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : butterfly_pipe_pkg
//  Purpose  : Shared defaults and the signed narrowing helper (wrap or clamp)
//             used by the butterfly pipeline.
//  Revision : 1.0  initial release
// ============================================================================
package butterfly_pipe_pkg;

    localparam int c_DEF_W     = 15;
    localparam int c_DEF_SHIFT = 2;
    localparam int c_DEF_CNT_W = 16;

    // Working width of the narrowing helper; every caller sign-extends into it.
    localparam int c_CLIP_W    = 64;

    typedef struct packed {
        logic                       ovf;
        logic signed [c_CLIP_W-1:0] val;
    } clip_t;

    // Narrow x to out_w signed bits. ovf reports an out-of-range input in
    // either mode; val is clamped when sat=1 and passed through otherwise
    // (the caller keeps the low out_w bits, which gives wrap behaviour).
    function automatic clip_t sat_clip(input logic signed [c_CLIP_W-1:0] x,
                                       input int                         out_w,
                                       input logic                       sat);
        logic signed [c_CLIP_W-1:0] maxv;
        logic signed [c_CLIP_W-1:0] minv;
        clip_t                      r;
        maxv  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv  = -(64'sd1 <<< (out_w - 1));
        r.ovf = (x > maxv) || (x < minv);
        if (sat && (x > maxv)) begin
            r.val = maxv;
        end else if (sat && (x < minv)) begin
            r.val = minv;
        end else begin
            r.val = x;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bf_sat.sv
`default_nettype none
// ============================================================================
//  Module   : bf_sat
//  Purpose  : Combinational signed narrowing from IN_W to OUT_W bits with
//             per-beat wrap/saturate selection and an overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module bf_sat
    import butterfly_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 15
) (
    input  logic signed [IN_W-1:0]  i_din,
    input  logic                    i_sat,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_ovf
);

    logic signed [c_CLIP_W-1:0] w_ext;
    clip_t                      w_res;

    // Sign-extend into the helper's working width, then narrow.
    assign w_ext  = c_CLIP_W'(i_din);
    assign w_res  = sat_clip(w_ext, OUT_W, i_sat);
    assign o_dout = OUT_W'(w_res.val);
    assign o_ovf  = w_res.ovf;

endmodule
`default_nettype wire

// File: rtl/butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : butterfly_pipe
//  Purpose  : Two-stage radix-2 butterfly (a+b, (a-b)<<SHIFT) with per-beat
//             wrap/saturate mode, overflow flags, valid/ready flow control
//             and a saturating overflow-beat counter.
//  Revision : 1.0  initial release
// ============================================================================
module butterfly_pipe
    import butterfly_pipe_pkg::*;
#(
    parameter int W     = c_DEF_W,
    parameter int SHIFT = c_DEF_SHIFT,
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] ai,
    input  logic signed [W-1:0] bi,
    input  logic                in_sat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] ao,
    output logic signed [W-1:0] bo,
    output logic [1:0]          ovf,
    output logic [CNT_W-1:0]    ovf_cnt,
    input  logic                cnt_clr
);

    localparam int               c_DW      = W + 1 + SHIFT;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Whole pipeline advances together; a held output stalls both stages.
    logic w_en;

    // Stage 1: exact-precision sum and difference plus the beat's mode.
    logic              r_s1_valid;
    logic signed [W:0] r_s1_sum;
    logic signed [W:0] r_s1_diff;
    logic              r_s1_sat;

    // Stage 2: narrowed results.
    logic                r_s2_valid;
    logic signed [W-1:0] r_ao;
    logic signed [W-1:0] r_bo;
    logic [1:0]          r_ovf;
    logic [CNT_W-1:0]    r_cnt;

    logic signed [W:0]      w_sum_full;
    logic signed [W:0]      w_diff_full;
    logic signed [c_DW-1:0] w_diff_ext;
    logic signed [c_DW-1:0] w_diff_sh;
    logic signed [W-1:0]    w_ao;
    logic signed [W-1:0]    w_bo;
    logic                   w_ovf_a;
    logic                   w_ovf_b;
    logic                   w_deliver;

    assign w_en     = out_ready || !r_s2_valid;
    assign in_ready = w_en;

    assign w_sum_full  = (W+1)'(ai) + (W+1)'(bi);
    assign w_diff_full = (W+1)'(ai) - (W+1)'(bi);

    // Widen before shifting so no significant bit is lost ahead of the range check.
    assign w_diff_ext = c_DW'(r_s1_diff);
    assign w_diff_sh  = w_diff_ext <<< SHIFT;

    bf_sat #(
        .IN_W  (W + 1),
        .OUT_W (W)
    ) u_sat_sum (
        .i_din  (r_s1_sum),
        .i_sat  (r_s1_sat),
        .o_dout (w_ao),
        .o_ovf  (w_ovf_a)
    );

    bf_sat #(
        .IN_W  (c_DW),
        .OUT_W (W)
    ) u_sat_diff (
        .i_din  (w_diff_sh),
        .i_sat  (r_s1_sat),
        .o_dout (w_bo),
        .o_ovf  (w_ovf_b)
    );

    // Stage 1 register: capture the input beat (or a bubble) when advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_diff  <= '0;
            r_s1_sat   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum  <= w_sum_full;
                r_s1_diff <= w_diff_full;
                r_s1_sat  <= in_sat;
            end
        end
    end

    // Stage 2 register: capture narrowed results of a valid stage-1 beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_ao       <= '0;
            r_bo       <= '0;
            r_ovf      <= 2'b00;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_ao  <= w_ao;
                r_bo  <= w_bo;
                r_ovf <= {w_ovf_b, w_ovf_a};
            end
        end
    end

    // A beat is counted only on the cycle it actually leaves the block.
    assign w_deliver = r_s2_valid && out_ready && (r_ovf != 2'b00);

    // Saturating overflow-beat counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_deliver && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign ao        = r_ao;
    assign bo        = r_bo;
    assign ovf       = r_ovf;
    assign ovf_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_butterfly_pipe
//  Purpose  : Directed self-checking bench for butterfly_pipe (W=15, SHIFT=2),
//             plus a CNT_W=2 instance sharing the stimulus for counter limits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_butterfly_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [14:0] ai;
    logic signed [14:0] bi;
    logic               in_sat;
    logic               out_valid;
    logic               out_ready;
    logic signed [14:0] ao;
    logic signed [14:0] bo;
    logic [1:0]         ovf;
    logic [15:0]        ovf_cnt;
    logic               cnt_clr;

    logic               in_ready2;
    logic               out_valid2;
    logic signed [14:0] ao2;
    logic signed [14:0] bo2;
    logic [1:0]         ovf2;
    logic [1:0]         cnt2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    butterfly_pipe #(.W(15), .SHIFT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ai(ai), .bi(bi), .in_sat(in_sat), .out_valid(out_valid),
        .out_ready(out_ready), .ao(ao), .bo(bo), .ovf(ovf),
        .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
    );

    butterfly_pipe #(.W(15), .SHIFT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .ai(ai), .bi(bi), .in_sat(in_sat), .out_valid(out_valid2),
        .out_ready(out_ready), .ao(ao2), .bo(bo2), .ovf(ovf2),
        .ovf_cnt(cnt2), .cnt_clr(cnt_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input logic s);
        in_valid = 1'b1;
        ai       = 15'(a);
        bi       = 15'(b);
        in_sat   = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ai = 15'(7); bi = 15'(3); in_sat = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        step(); step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (ao !== 15'(0) || bo !== 15'(0)) $display("FAIL reset_data got ao=%0d bo=%0d exp=0/0", ao, bo); else n_pass++;
        n_total++; if (ovf !== 2'b00) $display("FAIL reset_ovf got=%b exp=00", ovf); else n_pass++;
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", ovf_cnt); else n_pass++;
        in_valid = 1'b0;
        rst = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        step(); step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_beat_dropped got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_basic();
        send(100, 50, 1'b0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_latency got=%b exp=0", out_valid); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (ao !== 15'(150) || bo !== 15'(200)) $display("FAIL basic_data got ao=%0d bo=%0d exp=150/200", ao, bo); else n_pass++;
        n_total++; if (ovf !== 2'b00) $display("FAIL basic_ovf got=%b exp=00", ovf); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL basic_cnt got=%0d exp=0", ovf_cnt); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        send(16000, 1000, 1'b0);
        step();
        n_total++; if (ao !== 15'(-15768) || bo !== 15'(-5536)) $display("FAIL wrap_data got ao=%0d bo=%0d exp=-15768/-5536", ao, bo); else n_pass++;
        n_total++; if (ovf !== 2'b11) $display("FAIL wrap_ovf got=%b exp=11", ovf); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd1) $display("FAIL wrap_cnt got=%0d exp=1", ovf_cnt); else n_pass++;
        send(16000, 1000, 1'b1);
        step();
        n_total++; if (ao !== 15'(16383) || bo !== 15'(16383)) $display("FAIL sat_data got ao=%0d bo=%0d exp=16383/16383", ao, bo); else n_pass++;
        n_total++; if (ovf !== 2'b11) $display("FAIL sat_ovf got=%b exp=11", ovf); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd2) $display("FAIL sat_cnt got=%0d exp=2", ovf_cnt); else n_pass++;
        send(-16384, 16383, 1'b1);
        step();
        n_total++; if (ao !== 15'(-1) || bo !== 15'(-16384)) $display("FAIL neg_data got ao=%0d bo=%0d exp=-1/-16384", ao, bo); else n_pass++;
        n_total++; if (ovf !== 2'b10) $display("FAIL neg_ovf got=%b exp=10", ovf); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd3) $display("FAIL neg_cnt got=%0d exp=3", ovf_cnt); else n_pass++;
    endtask

    task automatic test_mode_switch();
        in_valid = 1'b1; ai = 15'(16000); bi = 15'(1000); in_sat = 1'b0;
        step();
        in_sat = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++; if (ao !== 15'(-15768) || bo !== 15'(-5536)) $display("FAIL mode_beat0 got ao=%0d bo=%0d exp=-15768/-5536", ao, bo); else n_pass++;
        step();
        n_total++; if (ao !== 15'(16383) || bo !== 15'(16383)) $display("FAIL mode_beat1 got ao=%0d bo=%0d exp=16383/16383", ao, bo); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mode_valid got=%b exp=1", out_valid); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd5) $display("FAIL mode_cnt got=%0d exp=5", ovf_cnt); else n_pass++;
    endtask

    task automatic test_stall_stream();
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid = 1'b1; ai = 15'(sent * 10 + 1); bi = 15'(sent); in_sat = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); else n_pass++;
                n_total++; if (out_valid !== 1'b1 || ao !== 15'(11 * got + 1)) $display("FAIL stall_hold cyc=%0d got v=%b ao=%0d exp v=1 ao=%0d", cyc, out_valid, ao, 11 * got + 1); else n_pass++;
            end else begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_total++;
                if (ao !== 15'(11 * got + 1) || bo !== 15'((9 * got + 1) * 4))
                    $display("FAIL stream_beat%0d got ao=%0d bo=%0d exp=%0d/%0d", got, ao, bo, 11 * got + 1, (9 * got + 1) * 4);
                else n_pass++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_total++; if (got != 8) $display("FAIL stream_count got=%0d exp=8", got); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_no_dup got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (ovf_cnt !== 16'd5) $display("FAIL stream_cnt got=%0d exp=5", ovf_cnt); else n_pass++;
    endtask

    task automatic test_cnt_sat_clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ai = 15'(16000); bi = 15'(1000); in_sat = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        n_total++; if (ovf_cnt !== 16'd5) $display("FAIL cnt16_five got=%0d exp=5", ovf_cnt); else n_pass++;
        n_total++; if (cnt2 !== 2'd3) $display("FAIL cnt2_saturate got=%0d exp=3", cnt2); else n_pass++;
        send(16000, 1000, 1'b0);
        step();
        n_total++; if (out_valid !== 1'b1 || ovf !== 2'b11) $display("FAIL clr_setup got v=%b ovf=%b exp v=1 ovf=11", out_valid, ovf); else n_pass++;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL clr_priority got=%0d exp=0", ovf_cnt); else n_pass++;
        n_total++; if (cnt2 !== 2'd0) $display("FAIL clr_priority2 got=%0d exp=0", cnt2); else n_pass++;
        step();
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL clr_single_count got=%0d exp=0", ovf_cnt); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; ai = 15'(16000); bi = 15'(1000); in_sat = 1'b0;
        step();
        ai = 15'(100); bi = 15'(50);
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_inflight got=%b exp=1", out_valid); else n_pass++;
        rst = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL mid_cnt got=%0d exp=0", ovf_cnt); else n_pass++;
        rst = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b exp=1", in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (out_valid !== 1'b0) $display("FAIL mid_ghost cyc=%0d got=%b exp=0", i, out_valid); else n_pass++;
        end
        n_total++; if (ovf_cnt !== 16'd0) $display("FAIL mid_cnt_after got=%0d exp=0", ovf_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ai = '0; bi = '0; in_sat = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_mode_switch();
        test_stall_stream();
        test_cnt_sat_clear();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter W, default 15: signed data width of all operands and results.
REQ-002 SHALL have parameter SHIFT, default 2: left-shift applied to the difference path, range 0..W-1.
REQ-003 SHALL have parameter CNT_W, default 16: overflow counter width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: ai/bi/in_sat valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts the input beat this cycle.
REQ-008 SHALL have port ai, input, W signed: operand A.
REQ-009 SHALL have port bi, input, W signed: operand B.
REQ-010 SHALL have port in_sat, input, 1: per-beat mode, 0 = wrap, 1 = saturate.
REQ-011 SHALL have port out_valid, output, 1: ao/bo/ovf valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the output beat.
REQ-013 SHALL have port ao, output, W signed: sum result.
REQ-014 SHALL have port bo, output, W signed: shifted difference result.
REQ-015 SHALL have port ovf, output, 2: {bo overflowed, ao overflowed} for the current output beat.
REQ-016 SHALL have port ovf_cnt, output, CNT_W: count of accepted output beats with any overflow.
REQ-017 SHALL have port cnt_clr, input, 1: synchronous clear of ovf_cnt.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready, and SHALL be delivered when out_valid && out_ready.
REQ-019 Pipeline SHALL be 2 stages: S1 registers the full-precision W+1-bit sum a+b, the difference a-b, and in_sat. S2 registers the shifted, wrapped or saturated W-bit results and ovf.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid when unstalled; throughput SHALL be 1 beat/cycle.
REQ-021 Advance enable SHALL be en = out_ready || !out_valid; in_ready SHALL equal en, combinationally, with no dependence on in_valid.
REQ-022 When en=0, both stages SHALL hold and ao/bo/ovf/out_valid SHALL remain stable.
REQ-023 When en=1, S1 valid SHALL load in_valid and S2 valid SHALL load S1 valid; a bubble SHALL propagate as invalid.
REQ-024 Difference path: d = (a-b) at W+1 bits, then sign-extended to W+1+SHIFT bits and shifted left by SHIFT, with no truncation before the range check.
REQ-025 Wrap mode (in_sat=0): ao SHALL be the low W bits of the sum and bo the low W bits of the shifted difference, identical to the legacy fixed-W=15/SHIFT=2 butterfly.
REQ-026 Saturate mode (in_sat=1): any out-of-range result SHALL clamp to 2^(W-1)-1 or -2^(W-1) according to sign.
REQ-027 ovf[0]/ovf[1] SHALL be 1 when the exact sum or shifted difference lies outside [-2^(W-1), 2^(W-1)-1], in either mode.
REQ-028 The mode SHALL travel with its beat; a mode change between consecutive beats SHALL take effect per beat with no pipeline flush.
REQ-029 ovf_cnt SHALL increment by 1 on each delivered beat with ovf != 0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-030 cnt_clr SHALL zero ovf_cnt next cycle, with priority over a simultaneous increment.
REQ-031 Undelivered beats held under stall SHALL NOT be counted more than once.

Reset
REQ-032 While rst=1, at the next clk edge: S1/S2 valid=0, out_valid=0, ao=0, bo=0, ovf=0, ovf_cnt=0.
REQ-033 Reset mid-stream SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Beats presented during rst SHALL NOT be accepted into the pipeline.

Structure
REQ-035 A shared package SHALL hold the default W, SHIFT, CNT_W constants and a sat_clip function (narrowing a wide signed value to W bits, returning result plus overflow flag).
REQ-036 A single sub-module bf_sat (parameter IN_W, OUT_W; combinational clamp/wrap plus overflow flag) SHALL be instantiated twice in S2; there SHALL be no other hierarchy.
REQ-037 The design SHALL contain no latches, and no combinational path other than out_ready->in_ready.

Verification (W=15, SHIFT=2)
REQ-038 ai=100, bi=50, in_sat=0, out_ready=1 -> 2 cycles later ao=150, bo=200, ovf=00, ovf_cnt unchanged.
REQ-039 ai=16000, bi=1000, wrap -> ao=-15768, bo=-5536, ovf=11, ovf_cnt+1; same operands with saturate -> ao=16383, bo=16383, ovf=11.
REQ-040 ai=-16384, bi=16383, saturate -> ao=-1, bo=-16384, ovf=10.
REQ-041 Streaming 8 beats with out_ready=0 for cycles 3-5 -> in_ready=0 during the stall, outputs held stable, all 8 delivered in order, none duplicated or lost.
REQ-042 ovf_cnt preset near max via overflow beats, with cnt_clr asserted on the same cycle as an overflowing delivery -> ovf_cnt=0; with CNT_W=2 and 5 overflow beats -> ovf_cnt=3.
REQ-043 rst asserted with 2 beats in flight -> out_valid=0 next cycle, those beats never appear, ovf_cnt=0.
